// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that hands one requester byte at a time to a UART transmitter.
// Watches the transmitter's ready handshake and raises a sticky error if a byte is never accepted.
module uart_tx_sched #(
    parameter int N_REQ       = 4,
    parameter int SIZE        = 8,
    parameter int ACK_TIMEOUT = 16,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [N_REQ*SIZE-1:0] DATA_IN,
    input  logic                  TXRDY,
    output logic [N_REQ-1:0]      GNT,
    output logic [SIZE-1:0]       TX_DATA,
    output logic                  TX_START,
    output logic [ID_W-1:0]       CUR_ID,
    output logic                  BUSY,
    output logic                  ERR
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [7:0]       TIMEOUT_C = 8'(ACK_TIMEOUT);
    localparam logic [ID_W-1:0]  ID_ONE    = ID_W'(1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] GNT_ONE   = N_REQ'(1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   ptr_nxt_s;
    logic [ID_W-1:0]   cur_id_r;
    logic [ID_W-1:0]   cur_id_nxt_s;
    logic [ID_W-1:0]   winner_s;
    logic [7:0]        cnt_r;
    logic [7:0]        cnt_nxt_s;
    logic [N_REQ-1:0]  gnt_r;
    logic [N_REQ-1:0]  gnt_nxt_s;
    logic [SIZE-1:0]   tx_data_r;
    logic [SIZE-1:0]   tx_data_nxt_s;
    logic              tx_start_r;
    logic              tx_start_nxt_s;
    logic              busy_r;
    logic              err_r;
    logic              err_nxt_s;
    logic              launch_s;
    logic              timeout_s;

    // First pending request at or after ptr, wrapping; indices never leave 0..N_REQ-1.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [ID_W-1:0]  ptr);
        logic            found;
        logic [ID_W-1:0] pick;
        int              idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign winner_s  = rr_pick(REQ, ptr_r);
    assign launch_s  = (state_r == ST_IDLE) && TXRDY && (|REQ);
    assign timeout_s = (state_r == ST_WAIT_ACK) && TXRDY && ((cnt_r + 8'd1) == TIMEOUT_C);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) state_nxt_s = ST_LAUNCH;
                else          state_nxt_s = ST_IDLE;
            end
            ST_LAUNCH: state_nxt_s = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!TXRDY)        state_nxt_s = ST_WAIT_DONE;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else               state_nxt_s = ST_WAIT_ACK;
            end
            ST_WAIT_DONE: begin
                if (TXRDY) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_WAIT_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values; grant/start are set on the way into LAUNCH so they
    // are registered yet visible during the LAUNCH cycle itself.
    always_comb begin
        gnt_nxt_s      = '0;
        tx_start_nxt_s = 1'b0;
        tx_data_nxt_s  = tx_data_r;
        cur_id_nxt_s   = cur_id_r;
        ptr_nxt_s      = ptr_r;
        cnt_nxt_s      = cnt_r;
        err_nxt_s      = err_r | timeout_s;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    gnt_nxt_s      = GNT_ONE << winner_s;
                    tx_start_nxt_s = 1'b1;
                    tx_data_nxt_s  = DATA_IN[int'(winner_s)*SIZE +: SIZE];
                    cur_id_nxt_s   = winner_s;
                end else begin
                    gnt_nxt_s      = '0;
                end
            end
            ST_LAUNCH: begin
                cnt_nxt_s = 8'd0;
                if (cur_id_r == ID_LAST) ptr_nxt_s = '0;
                else                     ptr_nxt_s = cur_id_r + ID_ONE;
            end
            ST_WAIT_ACK: begin
                if (TXRDY) cnt_nxt_s = cnt_r + 8'd1;
                else       cnt_nxt_s = cnt_r;
            end
            ST_WAIT_DONE: cnt_nxt_s = cnt_r;
            default:      cnt_nxt_s = 8'd0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gnt_r      <= '0;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            cur_id_r   <= '0;
            ptr_r      <= '0;
            cnt_r      <= 8'd0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            gnt_r      <= gnt_nxt_s;
            tx_start_r <= tx_start_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            cur_id_r   <= cur_id_nxt_s;
            ptr_r      <= ptr_nxt_s;
            cnt_r      <= cnt_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            err_r      <= err_nxt_s;
        end
    end

    assign GNT      = gnt_r;
    assign TX_START = tx_start_r;
    assign TX_DATA  = tx_data_r;
    assign CUR_ID   = cur_id_r;
    assign BUSY     = busy_r;
    assign ERR      = err_r;

endmodule
